// File: rtl/ahb2axi_rdata_return.sv
// AXI R-channel return path of the AXI-to-AHB bridge: buffers AHB read beats of one burst
// and replays them with RID/RRESP/RLAST. Define ERR_STICKY_EN to make SLVERR sticky per burst.
module ahb2axi_rdata_return #(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              ahb_rvalid,
  input  logic [DATA_W-1:0] ahb_rdata,
  input  logic              ahb_rerr,
  output logic              ahb_space,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [ID_W-1:0]   rid,
  output logic [1:0]        rresp,
  output logic              rlast
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] SPACE_CNT = (DEPTH_LOG2+1)'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                  r_state;
  logic                    r_cmd_ready;
  logic [ID_W-1:0]         r_id;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W:0]          r_rx_cnt;
  logic [LEN_W:0]          r_tx_cnt;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [DATA_W:0]         r_mem [DEPTH];

  logic                    w_stream;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_last;
  logic                    w_err_in;
  logic [DATA_W:0]         w_head;

  assign w_stream = (r_state == S_STREAM);
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_last   = (r_tx_cnt == {1'b0, r_len});
  assign w_pop    = rvalid & rready;
  assign w_push   = ahb_rvalid & w_stream & (r_rx_cnt <= {1'b0, r_len}) & (~w_full | w_pop);

`ifdef ERR_STICKY_EN
  logic r_err_sticky;

  assign w_err_in = ahb_rerr | r_err_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_err_sticky <= 1'b0;
    else if (!w_stream)            r_err_sticky <= 1'b0;
    else if (w_pop && w_last)      r_err_sticky <= 1'b0;
    else if (w_push && ahb_rerr)   r_err_sticky <= 1'b1;
  end
`else
  assign w_err_in = ahb_rerr;
`endif

  // Output fields are forced to zero while nothing is presented so reset shows clean values.
  assign rvalid    = w_stream & ~w_empty;
  assign rdata     = rvalid ? w_head[DATA_W-1:0] : '0;
  assign rresp     = (rvalid & w_head[DATA_W]) ? 2'b10 : 2'b00;
  assign rlast     = rvalid & w_last;
  assign rid       = r_id;
  assign cmd_ready = r_cmd_ready;
  // Occupancy is always zero in IDLE, so space reads high there and after reset.
  assign ahb_space = (r_count < SPACE_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_id        <= '0;
      r_len       <= '0;
      r_rx_cnt    <= '0;
      r_tx_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_id        <= cmd_id;
            r_len       <= cmd_len;
            r_rx_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_state     <= S_STREAM;
            r_cmd_ready <= 1'b0;
          end
        end
        S_STREAM: begin
          if (w_push) r_rx_cnt <= r_rx_cnt + (LEN_W+1)'(1);
          if (w_pop)  r_tx_cnt <= r_tx_cnt + (LEN_W+1)'(1);
          if (w_pop && w_last) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the beat array has no reset; stale entries are never observable because
  // pointers and count are reset and rdata is gated by rvalid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_err_in, ahb_rdata};
  end

endmodule

// File: tb/tb_ahb2axi_rdata_return.sv
// Self-checking bench for ahb2axi_rdata_return: table-driven bursts plus hand-written
// sequences for back-pressure, full-buffer push/pop and mid-burst reset.
module tb_ahb2axi_rdata_return;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic        ahb_rvalid;
  logic [31:0] ahb_rdata;
  logic        ahb_rerr;
  logic        ahb_space;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;

  ahb2axi_rdata_return dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_len    (cmd_len),
    .ahb_rvalid (ahb_rvalid),
    .ahb_rdata  (ahb_rdata),
    .ahb_rerr   (ahb_rerr),
    .ahb_space  (ahb_space),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rid        (rid),
    .rresp      (rresp),
    .rlast      (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ERR_STICKY_EN
  localparam logic [1:0] SR = 2'b10;
`else
  localparam logic [1:0] SR = 2'b00;
`endif

  typedef struct {
    logic        cv;
    logic [3:0]  cid;
    logic [7:0]  clen;
    logic        av;
    logic [31:0] ad;
    logic        ae;
    logic        rr;
    logic        e_cr;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [3:0]  e_rid;
    logic [1:0]  e_resp;
    logic        e_rl;
    logic        e_sp;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] exp_q[$];
  logic [3:0]  exp_rid;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic cv, input logic [3:0] cid, input logic [7:0] clen,
                              input logic av, input logic [31:0] ad, input logic ae,
                              input logic rr, input logic e_cr, input logic e_rv,
                              input logic [31:0] e_rd, input logic [3:0] e_rid,
                              input logic [1:0] e_resp, input logic e_rl, input logic e_sp);
    vec_t v;
    v = '{cv, cid, clen, av, ad, ae, rr, e_cr, e_rv, e_rd, e_rid, e_resp, e_rl, e_sp};
    return v;
  endfunction

  // One clock of streaming stimulus; any beat handshaken this cycle is scored against exp_q.
  task automatic cycle(input logic av, input logic [31:0] ad, input logic rr);
    logic [31:0] e;
    ahb_rvalid = av;
    ahb_rdata  = ad;
    ahb_rerr   = 1'b0;
    rready     = rr;
    if (rvalid && rready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", rdata, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("stream_rdata", rdata, e);
        check("stream_rid", {28'd0, rid}, {28'd0, exp_rid});
        check("stream_rlast", {31'd0, rlast}, {31'd0, exp_q.size() == 0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [7:0] len);
    ahb_rvalid = 1'b0;
    rready     = 1'b0;
    cmd_valid  = 1'b1;
    cmd_id     = id;
    cmd_len    = len;
    exp_rid    = id;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, 32'd0, 1'b1);
    check(name, exp_q.size(), 32'd0);
    check({name, "_idle"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0;
    ahb_rvalid = 1'b0; ahb_rdata = '0; ahb_rerr = 1'b0; rready = 1'b0; exp_rid = '0;

    // T1 len=3 id=5, T3 error on beat 1, T4 single beat with trailing extra beats
    vt.push_back(mk(1,5,3, 0,0,0,0, 1,0,0,0,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'hA0,0,1, 0,0,0,5,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'hA1,0,1, 0,1,32'hA0,5,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'hA2,0,1, 0,1,32'hA1,5,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'hA3,0,1, 0,1,32'hA2,5,0,0,1));
    vt.push_back(mk(0,0,0, 0,0,0,1, 0,1,32'hA3,5,0,1,1));
    vt.push_back(mk(0,0,0, 0,0,0,1, 1,0,0,5,0,0,1));
    vt.push_back(mk(1,3,3, 0,0,0,0, 1,0,0,5,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'h10,0,1, 0,0,0,3,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'h11,1,1, 0,1,32'h10,3,2'b00,0,1));
    vt.push_back(mk(0,0,0, 1,32'h12,0,1, 0,1,32'h11,3,2'b10,0,1));
    vt.push_back(mk(0,0,0, 1,32'h13,0,1, 0,1,32'h12,3,SR,0,1));
    vt.push_back(mk(0,0,0, 0,0,0,1, 0,1,32'h13,3,SR,1,1));
    vt.push_back(mk(0,0,0, 0,0,0,1, 1,0,0,3,0,0,1));
    vt.push_back(mk(1,9,0, 0,0,0,0, 1,0,0,3,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'h55,0,1, 0,0,0,9,0,0,1));
    vt.push_back(mk(0,0,0, 1,32'h66,0,1, 0,1,32'h55,9,0,1,1));
    vt.push_back(mk(0,0,0, 1,32'h77,0,1, 1,0,0,9,0,0,1));
    vt.push_back(mk(0,0,0, 0,0,0,1, 1,0,0,9,0,0,1));

    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rvalid",    {31'd0, rvalid},    32'd0);
    check("rst_rlast",     {31'd0, rlast},     32'd0);
    check("rst_rresp",     {30'd0, rresp},     32'd0);
    check("rst_rid",       {28'd0, rid},       32'd0);
    check("rst_rdata",     rdata,              32'd0);
    check("rst_ahb_space", {31'd0, ahb_space}, 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      cmd_valid  = vt[i].cv;  cmd_id    = vt[i].cid; cmd_len  = vt[i].clen;
      ahb_rvalid = vt[i].av;  ahb_rdata = vt[i].ad;  ahb_rerr = vt[i].ae;
      rready     = vt[i].rr;
      check($sformatf("v%0d_cmd_ready", i), {31'd0, cmd_ready}, {31'd0, vt[i].e_cr});
      check($sformatf("v%0d_rvalid", i),    {31'd0, rvalid},    {31'd0, vt[i].e_rv});
      check($sformatf("v%0d_rdata", i),     rdata,              vt[i].e_rd);
      check($sformatf("v%0d_rid", i),       {28'd0, rid},       {28'd0, vt[i].e_rid});
      check($sformatf("v%0d_rresp", i),     {30'd0, rresp},     {30'd0, vt[i].e_resp});
      check($sformatf("v%0d_rlast", i),     {31'd0, rlast},     {31'd0, vt[i].e_rl});
      check($sformatf("v%0d_ahb_space", i), {31'd0, ahb_space}, {31'd0, vt[i].e_sp});
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; ahb_rvalid = 1'b0; ahb_rerr = 1'b0; rready = 1'b0;

    // T2: stall until 7 buffered, then stream the rest through the wrapping buffer
    send_cmd(4'd2, 8'd15);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h200 + k);
    for (int k = 0; k < 7; k++) begin
      check("t2_space_open", {31'd0, ahb_space}, 32'd1);
      cycle(1'b1, 32'h200 + k, 1'b0);
    end
    check("t2_space_at7", {31'd0, ahb_space}, 32'd0);
    check("t2_head", rdata, 32'h200);
    cycle(1'b0, 32'd0, 1'b0);
    check("t2_head_held", rdata, 32'h200);
    check("t2_rvalid_held", {31'd0, rvalid}, 32'd1);
    for (int k = 7; k < 16; k++) begin
      check("t2_space_steady", {31'd0, ahb_space}, 32'd0);
      cycle(1'b1, 32'h200 + k, 1'b1);
    end
    drain("t2_all_beats");

    // T6: fill to 8, a push while full is dropped, then push+pop while full
    send_cmd(4'd4, 8'd11);
    for (int k = 0; k < 12; k++) exp_q.push_back(32'h300 + k);
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h300 + k, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b0);
    check("t6_space_full", {31'd0, ahb_space}, 32'd0);
    check("t6_head", rdata, 32'h300);
    for (int k = 8; k < 12; k++) cycle(1'b1, 32'h300 + k, 1'b1);
    drain("t6_all_beats");

    // T5: reset with 3 beats buffered, then a fresh burst returns only new data
    send_cmd(4'd6, 8'd7);
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h500 + k, 1'b0);
    ahb_rvalid = 1'b0;
    check("t5_pre_rvalid", {31'd0, rvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rvalid",    {31'd0, rvalid},    32'd0);
    check("t5_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("t5_rst_rid",       {28'd0, rid},       32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    send_cmd(4'd7, 8'd1);
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h601);
    cycle(1'b1, 32'h600, 1'b1);
    cycle(1'b1, 32'h601, 1'b1);
    drain("t5_new_burst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
